// File: rtl/traffic_phase_scheduler.sv
// Timed phase scheduler for a two-street intersection with an on-demand pedestrian walk phase.
// A clock prescaler generates timing ticks; a per-phase tick timer enforces min/max green times.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 10,
    parameter int MIN_GREEN = 6,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1,
    parameter int WALK      = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Sa,
    input  logic       Sb,
    input  logic       ped_req,
    output logic       Ra,
    output logic       Ya,
    output logic       Ga,
    output logic       Rb,
    output logic       Yb,
    output logic       Gb,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_A_GRN   = 3'd0,
        S_A_YEL   = 3'd1,
        S_ALL_RED = 3'd2,
        S_B_GRN   = 3'd3,
        S_B_YEL   = 3'd4,
        S_WALK    = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     presc;
    logic [CNT_W-1:0]  timer;
    logic              last_side;
    logic              tick;
    logic              green_min;
    logic              green_max;
    logic              in_green;
    logic              yel_done;
    logic              red_done;
    logic              walk_done;
    logic              phase_change;

    assign tick         = (presc == PW'(TICK_DIV - 1));
    assign green_min    = (timer >= CNT_W'(MIN_GREEN - 1));
    assign green_max    = (timer == CNT_W'(MAX_GREEN - 1));
    assign in_green     = (state == S_A_GRN) || (state == S_B_GRN);
    assign yel_done     = tick && (timer == CNT_W'(YELLOW - 1));
    assign red_done     = tick && (timer == CNT_W'(ALL_RED - 1));
    assign walk_done    = tick && (timer == CNT_W'(WALK - 1));
    assign phase_change = (state_next != state);

    always_comb begin
        state_next = state;
        case (state)
            S_A_GRN:
                if (tick && green_min && (Sb || ped_pending) && (!Sa || green_max))
                    state_next = S_A_YEL;
            S_A_YEL:
                if (yel_done) state_next = S_ALL_RED;
            S_ALL_RED:
                if (red_done) begin
                    if (ped_pending)    state_next = S_WALK;
                    else if (last_side) state_next = S_A_GRN;
                    else                state_next = S_B_GRN;
                end
            S_B_GRN:
                if (tick && green_min && (Sa || ped_pending) && (!Sb || green_max))
                    state_next = S_B_YEL;
            S_B_YEL:
                if (yel_done) state_next = S_ALL_RED;
            S_WALK:
                if (walk_done) state_next = last_side ? S_A_GRN : S_B_GRN;
            default:
                state_next = S_A_GRN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_A_GRN;
        end else begin
            state <= state_next;
        end
    end

    // Timing restarts from zero in every new phase; the green timer parks at MAX_GREEN-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            timer <= '0;
        end else if (phase_change) begin
            presc <= '0;
            timer <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && !(in_green && green_max))
                timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_side   <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            if (state == S_A_YEL && yel_done) last_side <= 1'b0;
            if (state == S_B_YEL && yel_done) last_side <= 1'b1;
            // Entering WALK serves the request and overrides a same-cycle press.
            if (state_next == S_WALK && state != S_WALK)
                ped_pending <= 1'b0;
            else if (ped_req && state != S_WALK)
                ped_pending <= 1'b1;
        end
    end

    always_comb begin
        Ga      = (state == S_A_GRN);
        Ya      = (state == S_A_YEL);
        Ra      = !(Ga || Ya);
        Gb      = (state == S_B_GRN);
        Yb      = (state == S_B_YEL);
        Rb      = !(Gb || Yb);
        walk    = (state == S_WALK);
        state_o = state;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with short timing parameters.
// Phase/lamp expectations are hand-derived cycle numbers counted from reset release.
module tb_traffic_phase_scheduler;

    localparam int TICK_DIV  = 2;
    localparam int MIN_GREEN = 3;
    localparam int MAX_GREEN = 6;
    localparam int YELLOW    = 2;
    localparam int ALL_RED   = 1;
    localparam int WALK      = 4;
    localparam int CNT_W     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       Sa, Sb, ped_req;
    logic       Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_pending;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    traffic_phase_scheduler #(
        .TICK_DIV (TICK_DIV),
        .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN),
        .YELLOW   (YELLOW),
        .ALL_RED  (ALL_RED),
        .WALK     (WALK),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Sa         (Sa),
        .Sb         (Sb),
        .ped_req    (ped_req),
        .Ra         (Ra),
        .Ya         (Ya),
        .Ga         (Ga),
        .Rb         (Rb),
        .Yb         (Yb),
        .Gb         (Gb),
        .walk       (walk),
        .ped_pending(ped_pending),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lamp vector {Ra,Ya,Ga,Rb,Yb,Gb,walk} expected for each phase code.
    function automatic logic [6:0] lamps_for(input int st);
        case (st)
            0:       return 7'b0011000;
            1:       return 7'b0101000;
            2:       return 7'b1001000;
            3:       return 7'b1000010;
            4:       return 7'b1000100;
            5:       return 7'b1001001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic phase(input string tag, input int st);
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_lamps"}, 32'({Ra, Ya, Ga, Rb, Yb, Gb, walk}), 32'(lamps_for(st)));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in cycle 0 (first cycle after release) with the given inputs.
    task automatic do_reset(input logic a, input logic b, input logic p);
        reset   = 1'b1;
        Sa      = a;
        Sb      = b;
        ped_req = p;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        int exp_st;

        // 1: idle intersection stays in A green.
        do_reset(1'b0, 1'b0, 1'b0);
        phase("reset", 0);
        chk("reset_pp", 32'(ped_pending), 32'd0);
        for (int c = 1; c <= 200; c++) begin
            step(1);
            phase("idle", 0);
        end

        // 2: B demand only; A green 6, yellow 4, all-red 2, B green at 12.
        do_reset(1'b0, 1'b1, 1'b0);
        for (int c = 0; c <= 12; c++) begin
            exp_st = (c < 6) ? 0 : (c < 10) ? 1 : (c < 12) ? 2 : 3;
            phase("bdemand", exp_st);
            if (c < 12) step(1);
        end

        // 3: both streets busy, greens run to MAX (12 clks each) and alternate.
        do_reset(1'b1, 1'b1, 1'b0);
        for (int c = 0; c <= 36; c++) begin
            exp_st = (c < 12) ? 0 : (c < 16) ? 1 : (c < 18) ? 2 :
                     (c < 30) ? 3 : (c < 34) ? 4 : (c < 36) ? 2 : 0;
            phase("maxgreen", exp_st);
            if (c < 36) step(1);
        end

        // Saturated A green with only A traffic exits on the first tick after B arrives.
        do_reset(1'b1, 1'b0, 1'b0);
        step(30);
        phase("sat_hold", 0);
        Sb = 1'b1;
        step(1);
        phase("sat_c31", 0);
        step(1);
        phase("sat_exit", 1);

        // 4: single-cycle pedestrian press in A green leads to WALK, then B green.
        do_reset(1'b0, 1'b0, 1'b0);
        step(2);
        chk("ped_before", 32'(ped_pending), 32'd0);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        chk("ped_latched", 32'(ped_pending), 32'd1);
        for (int c = 3; c <= 20; c++) begin
            exp_st = (c < 6) ? 0 : (c < 10) ? 1 : (c < 12) ? 2 : (c < 20) ? 5 : 3;
            phase("ped", exp_st);
            if (c == 11) chk("ped_pp_allred", 32'(ped_pending), 32'd1);
            if (c == 12) chk("ped_pp_walk", 32'(ped_pending), 32'd0);
            if (c < 20) step(1);
        end

        // 5: button held through WALK is ignored; no second walk afterwards.
        do_reset(1'b0, 1'b0, 1'b1);
        step(12);
        phase("held_walk", 5);
        chk("held_pp_walk", 32'(ped_pending), 32'd0);
        step(7);
        phase("held_walk_end", 5);
        chk("held_pp_c19", 32'(ped_pending), 32'd0);
        step(1);
        ped_req = 1'b0;
        phase("held_bgrn", 3);
        chk("held_pp_exit", 32'(ped_pending), 32'd0);
        step(20);
        phase("held_nowalk", 3);
        chk("held_pp_late", 32'(ped_pending), 32'd0);

        // 6: asynchronous reset during A yellow.
        do_reset(1'b0, 1'b1, 1'b0);
        step(1);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        step(6);
        phase("rst_pre", 1);
        chk("rst_pre_pp", 32'(ped_pending), 32'd1);
        reset = 1'b1;
        #1;
        phase("rst_async", 0);
        chk("rst_async_pp", 32'(ped_pending), 32'd0);
        step(1);
        reset = 1'b0;
        step(6);
        phase("rst_restart", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
